// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - 32x32 writeback register file with MEM/ALU arbitration and hold buffer (optional WB_BYPASS_EN)
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_wb,
  input  logic [ADDR_W-1:0] mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ldb,
  input  logic [1:0]        mem_bsel,
  input  logic              alu_wb,
  input  logic [ADDR_W-1:0] alu_dst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              alu_stall,
  output logic [31:0]       retire_cnt
);

  logic [DATA_W-1:0] regs [NREGS];

  logic              hold_valid;
  logic [ADDR_W-1:0] hold_dst;
  logic [DATA_W-1:0] hold_data;

  logic [7:0]        mem_byte;
  logic [DATA_W-1:0] mem_wdata;

  logic              commit_en;
  logic [ADDR_W-1:0] commit_dst;
  logic [DATA_W-1:0] commit_data;
  logic              hold_load;
  logic              hold_drain;

  // The stall is simply "hold buffer occupied": the ALU may not present a new result until it drains.
  assign alu_stall = hold_valid;

  // Byte-load lane select; the selected byte is zero-extended to the full word.
  always_comb begin
    mem_byte = mem_data[7:0];
    case (mem_bsel)
      2'd0: mem_byte = mem_data[7:0];
      2'd1: mem_byte = mem_data[15:8];
      2'd2: mem_byte = mem_data[23:16];
      2'd3: mem_byte = mem_data[31:24];
      default: mem_byte = mem_data[7:0];
    endcase
    mem_wdata = mem_ldb ? {{(DATA_W-8){1'b0}}, mem_byte} : mem_data;
  end

  // Single write port arbitration: MEM beats the held ALU result, which beats a fresh ALU result.
  always_comb begin
    commit_en   = 1'b0;
    commit_dst  = '0;
    commit_data = '0;
    hold_load   = 1'b0;
    hold_drain  = 1'b0;
    if (mem_wb) begin
      commit_en   = 1'b1;
      commit_dst  = mem_dst;
      commit_data = mem_wdata;
      // A fresh ALU result colliding with MEM is parked; while stalled alu_wb is ignored.
      hold_load   = alu_wb && !hold_valid;
    end else if (hold_valid) begin
      commit_en   = 1'b1;
      commit_dst  = hold_dst;
      commit_data = hold_data;
      hold_drain  = 1'b1;
    end else if (alu_wb) begin
      commit_en   = 1'b1;
      commit_dst  = alu_dst;
      commit_data = alu_data;
    end
  end

  // Register array write; r0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit_en && (commit_dst != '0)) begin
      regs[commit_dst] <= commit_data;
    end
  end

  // Hold buffer: captures a colliding ALU result, releases it on the first cycle without MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_dst   <= '0;
      hold_data  <= '0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      hold_dst   <= alu_dst;
      hold_data  <= alu_data;
    end else if (hold_drain) begin
      hold_valid <= 1'b0;
    end
  end

  // Every commit counts, including discarded writes to r0; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (commit_en) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  // Combinational read ports, optionally forwarding the value being committed this cycle.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
`ifdef WB_BYPASS_EN
    if (commit_en && (commit_dst != '0) && (rs1_addr == commit_dst)) rs1_data = commit_data;
    if (commit_en && (commit_dst != '0) && (rs2_addr == commit_dst)) rs2_data = commit_data;
`endif
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed self-checking bench for writeback_regfile
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        mem_wb;
  logic [4:0]  mem_dst;
  logic [31:0] mem_data;
  logic        mem_ldb;
  logic [1:0]  mem_bsel;
  logic        alu_wb;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        alu_stall;
  logic [31:0] retire_cnt;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_cnt;

  writeback_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .mem_wb(mem_wb), .mem_dst(mem_dst), .mem_data(mem_data),
    .mem_ldb(mem_ldb), .mem_bsel(mem_bsel),
    .alu_wb(alu_wb), .alu_dst(alu_dst), .alu_data(alu_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_stall(alu_stall), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_wb = 1'b0; mem_dst = '0; mem_data = '0; mem_ldb = 1'b0; mem_bsel = '0;
    alu_wb = 1'b0; alu_dst = '0; alu_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rs1_addr = '0; rs2_addr = '0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = i[4:0]; rs2_addr = 5'(31 - i);
      #1;
      n_cmp++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_regs idx=%0d rs1=%h rs2=%h required 0", i, rs1_data, rs2_data);
      end
    end
    n_cmp++;
    if (alu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b required 0", alu_stall); end
    n_cmp++;
    if (retire_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0d required 0", retire_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_cnt = 32'd0;
  endtask

  task automatic test_ldw_ldb();
    mem_wb = 1'b1; mem_dst = 5'd5; mem_data = 32'hA1B2C3D4; mem_ldb = 1'b0;
    tick();
    mem_dst = 5'd6; mem_ldb = 1'b1; mem_bsel = 2'd2;
    rs1_addr = 5'd5;
    #1;
    n_cmp++;
    if (rs1_data !== 32'hA1B2C3D4) begin n_bad++; $display("FAIL ldw_r5 got %h required a1b2c3d4", rs1_data); end
    tick();
    idle_inputs();
    exp_cnt = exp_cnt + 32'd2;
    rs2_addr = 5'd6;
    #1;
    n_cmp++;
    if (rs2_data !== 32'h000000B2) begin n_bad++; $display("FAIL ldb_r6 got %h required 000000b2", rs2_data); end
    n_cmp++;
    if (retire_cnt !== exp_cnt) begin n_bad++; $display("FAIL ldw_ldb_cnt got %0d required %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_collision();
    mem_wb = 1'b1; mem_dst = 5'd3; mem_data = 32'h11;
    alu_wb = 1'b1; alu_dst = 5'd4; alu_data = 32'h22;
    n_cmp++;
    if (alu_stall !== 1'b0) begin n_bad++; $display("FAIL coll_pre_stall got %b required 0", alu_stall); end
    tick();
    idle_inputs();
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    #1;
    n_cmp++;
    if (alu_stall !== 1'b1) begin n_bad++; $display("FAIL coll_stall got %b required 1", alu_stall); end
    n_cmp++;
    if (rs1_data !== 32'h11) begin n_bad++; $display("FAIL coll_r3 got %h required 11", rs1_data); end
    n_cmp++;
    if (rs2_data !== 32'h0) begin n_bad++; $display("FAIL coll_r4_early got %h required 0", rs2_data); end
    tick();
    exp_cnt = exp_cnt + 32'd2;
    n_cmp++;
    if (alu_stall !== 1'b0) begin n_bad++; $display("FAIL coll_unstall got %b required 0", alu_stall); end
    n_cmp++;
    if (rs2_data !== 32'h22) begin n_bad++; $display("FAIL coll_r4 got %h required 22", rs2_data); end
    n_cmp++;
    if (retire_cnt !== exp_cnt) begin n_bad++; $display("FAIL coll_cnt got %0d required %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    mem_wb = 1'b1; mem_dst = 5'd8; mem_data = 32'h80;
    alu_wb = 1'b1; alu_dst = 5'd9; alu_data = 32'h99;
    tick();
    // three further MEM results while the hold is full; ALU keeps pushing a result that must be ignored
    alu_dst = 5'd13; alu_data = 32'h1313;
    for (int k = 0; k < 3; k++) begin
      mem_dst = 5'(10 + k); mem_data = 32'(32'hA0 + k);
      #1;
      n_cmp++;
      if (alu_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_stall cycle=%0d got %b required 1", k, alu_stall); end
      tick();
    end
    mem_wb = 1'b0;
    rs1_addr = 5'd9; rs2_addr = 5'd12;
    #1;
    n_cmp++;
    if (alu_stall !== 1'b1 || rs1_data !== 32'h0) begin
      n_bad++; $display("FAIL b2b_before_drain stall=%b r9=%h required 1/0", alu_stall, rs1_data);
    end
    n_cmp++;
    if (rs2_data !== 32'hA2) begin n_bad++; $display("FAIL b2b_r12 got %h required a2", rs2_data); end
    tick();
    idle_inputs();
    exp_cnt = exp_cnt + 32'd5;
    rs2_addr = 5'd13;
    #1;
    n_cmp++;
    if (alu_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_unstall got %b required 0", alu_stall); end
    n_cmp++;
    if (rs1_data !== 32'h99) begin n_bad++; $display("FAIL b2b_r9 got %h required 99", rs1_data); end
    n_cmp++;
    if (rs2_data !== 32'h0) begin n_bad++; $display("FAIL b2b_ignored_r13 got %h required 0", rs2_data); end
    n_cmp++;
    if (retire_cnt !== exp_cnt) begin n_bad++; $display("FAIL b2b_cnt got %0d required %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_r0_write();
    alu_wb = 1'b1; alu_dst = 5'd0; alu_data = 32'hFFFF;
    tick();
    idle_inputs();
    exp_cnt = exp_cnt + 32'd1;
    rs1_addr = 5'd0;
    #1;
    n_cmp++;
    if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL r0_read got %h required 0", rs1_data); end
    n_cmp++;
    if (retire_cnt !== exp_cnt) begin n_bad++; $display("FAIL r0_cnt got %0d required %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
    alu_wb = 1'b1; alu_dst = 5'd7; alu_data = 32'h1234;
    tick();
    idle_inputs();
    mem_wb = 1'b1; mem_dst = 5'd7; mem_data = 32'hDEAD;
    rs1_addr = 5'd7;
`ifdef WB_BYPASS_EN
    exp_same = 32'hDEAD;
`else
    exp_same = 32'h1234;
`endif
    #1;
    n_cmp++;
    if (rs1_data !== exp_same) begin n_bad++; $display("FAIL bypass_same_cycle got %h required %h", rs1_data, exp_same); end
    tick();
    idle_inputs();
    exp_cnt = exp_cnt + 32'd2;
    #1;
    n_cmp++;
    if (rs1_data !== 32'hDEAD) begin n_bad++; $display("FAIL bypass_r7 got %h required dead", rs1_data); end
    n_cmp++;
    if (retire_cnt !== exp_cnt) begin n_bad++; $display("FAIL bypass_cnt got %0d required %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    mem_wb = 1'b1; mem_dst = 5'd14; mem_data = 32'hE0;
    alu_wb = 1'b1; alu_dst = 5'd15; alu_data = 32'hF0;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (alu_stall !== 1'b0) begin n_bad++; $display("FAIL midrst_stall got %b required 0", alu_stall); end
    n_cmp++;
    if (retire_cnt !== 32'd0) begin n_bad++; $display("FAIL midrst_cnt got %0d required 0", retire_cnt); end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = i[4:0]; rs2_addr = i[4:0];
      #1;
      n_cmp++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
        n_bad++; $display("FAIL midrst_regs idx=%0d rs1=%h rs2=%h required 0", i, rs1_data, rs2_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    rs1_addr = 5'd15;
    #1;
    n_cmp++;
    if (rs1_data !== 32'd0 || retire_cnt !== 32'd0) begin
      n_bad++; $display("FAIL midrst_hold_dropped r15=%h cnt=%0d required 0/0", rs1_data, retire_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_cnt = '0;
    test_reset();
    test_ldw_ldb();
    test_collision();
    test_back_to_back();
    test_r0_write();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
